// File: rtl/riscv_fetch_align.sv
`default_nettype none
// ============================================================================
// riscv_fetch_align
// RV64IMC fetch stage: PC register, word-aligned imem address, and alignment of
// 16/32-bit parcels, including 32-bit instructions that straddle a word.
// The C-extension aligner is enabled by defining RISCV_FETCH_CEXT_EN.
// Revision: 1.0
// ============================================================================
module riscv_fetch_align #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            i_riscv_fetch_clk,
  input  logic            i_riscv_fetch_rst,
  input  logic            i_riscv_fetch_stallpc,
  input  logic            i_riscv_fetch_pcsrc,
  input  logic [XLEN-1:0] i_riscv_fetch_target,
  output logic [XLEN-1:0] o_riscv_fetch_imemaddr,
  input  logic [31:0]     i_riscv_fetch_imemdata,
  output logic            o_riscv_fetch_valid,
  output logic [31:0]     o_riscv_fetch_inst,
  output logic            o_riscv_fetch_compressed,
  output logic [XLEN-1:0] o_riscv_fetch_pc,
  output logic [XLEN-1:0] o_riscv_fetch_pcplussize
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_word_base;

  assign w_word_base              = {r_pc[XLEN-1:2], 2'b00};
  assign o_riscv_fetch_pc         = r_pc;
  assign o_riscv_fetch_pcplussize = r_pc + (o_riscv_fetch_compressed ? XLEN'(2) : XLEN'(4));

`ifdef RISCV_FETCH_CEXT_EN
  typedef enum logic [0:0] {
    S_ALIGN = 1'b0,
    S_SPLIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_hold;
  logic        w_hold_load;
  logic [15:0] w_lo;
  logic [15:0] w_hi;
  logic        w_unused_target;

  assign w_lo            = i_riscv_fetch_imemdata[15:0];
  assign w_hi            = i_riscv_fetch_imemdata[31:16];
  assign w_unused_target = i_riscv_fetch_target[0];

  always_comb begin
    w_state_next             = r_state;
    w_pc_next                = r_pc;
    w_hold_load              = 1'b0;
    o_riscv_fetch_imemaddr   = w_word_base;
    o_riscv_fetch_valid      = 1'b1;
    o_riscv_fetch_inst       = i_riscv_fetch_imemdata;
    o_riscv_fetch_compressed = 1'b0;
    case (r_state)
      S_ALIGN: begin
        if (!r_pc[1]) begin
          if (w_lo[1:0] != 2'b11) begin
            o_riscv_fetch_inst       = {16'h0000, w_lo};
            o_riscv_fetch_compressed = 1'b1;
            w_pc_next                = r_pc + XLEN'(2);
          end else begin
            w_pc_next = r_pc + XLEN'(4);
          end
        end else if (w_hi[1:0] != 2'b11) begin
          o_riscv_fetch_inst       = {16'h0000, w_hi};
          o_riscv_fetch_compressed = 1'b1;
          w_pc_next                = r_pc + XLEN'(2);
        end else begin
          // Straddling 32-bit instruction: park the low half, fetch the next word.
          o_riscv_fetch_valid = 1'b0;
          w_hold_load         = 1'b1;
          w_state_next        = S_SPLIT;
        end
      end
      S_SPLIT: begin
        o_riscv_fetch_imemaddr = w_word_base + XLEN'(4);
        o_riscv_fetch_inst     = {w_lo, r_hold};
        w_pc_next              = r_pc + XLEN'(4);
        w_state_next           = S_ALIGN;
      end
      default: begin
        w_state_next = S_ALIGN;
      end
    endcase
  end

  always_ff @(posedge i_riscv_fetch_clk) begin
    if (i_riscv_fetch_rst) begin
      r_pc    <= RESET_PC;
      r_state <= S_ALIGN;
      r_hold  <= '0;
    end else if (i_riscv_fetch_pcsrc) begin
      r_pc    <= {i_riscv_fetch_target[XLEN-1:1], 1'b0};
      r_state <= S_ALIGN;
    end else if (!i_riscv_fetch_stallpc) begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
      if (w_hold_load) begin
        r_hold <= w_hi;
      end
    end
  end
`else
  logic [1:0] w_unused_target;

  assign w_unused_target = i_riscv_fetch_target[1:0];

  always_comb begin
    w_pc_next                = r_pc + XLEN'(4);
    o_riscv_fetch_imemaddr   = w_word_base;
    o_riscv_fetch_valid      = 1'b1;
    o_riscv_fetch_inst       = i_riscv_fetch_imemdata;
    o_riscv_fetch_compressed = 1'b0;
  end

  always_ff @(posedge i_riscv_fetch_clk) begin
    if (i_riscv_fetch_rst) begin
      r_pc <= RESET_PC;
    end else if (i_riscv_fetch_pcsrc) begin
      r_pc <= {i_riscv_fetch_target[XLEN-1:2], 2'b00};
    end else if (!i_riscv_fetch_stallpc) begin
      r_pc <= w_pc_next;
    end
  end
`endif

endmodule
`default_nettype wire
